// File: rtl/trap_controller_if.sv
`default_nettype none
// ============================================================================
// trap_controller_if : execute-stage / CSR-side signal bundle of the trap controller
// Rev 1.0 : initial release
// ============================================================================
interface trap_controller_if;
    logic        irq_software;
    logic        irq_timer;
    logic        irq_external;
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic        ex_valid;
    logic        ex_stall;
    logic [31:0] ex_pc;
    logic        interrupt_taken;
    logic        ecall_exception;
    logic        ebreak_exception;
    logic        mret_instruction;
    logic        interrupt_pending;
    logic [31:0] interrupt_cause;
    logic [31:0] trap_vector;
    logic        trap_csr_we;
    logic [11:0] trap_csr_addr;
    logic [31:0] trap_csr_wdata;
    logic        busy;

    modport master (
        input  irq_software, irq_timer, irq_external, mstatus, mie, mtvec,
               ex_valid, ex_stall, ex_pc, interrupt_taken, ecall_exception,
               ebreak_exception, mret_instruction,
        output interrupt_pending, interrupt_cause, trap_vector, trap_csr_we,
               trap_csr_addr, trap_csr_wdata, busy
    );

    modport slave (
        output irq_software, irq_timer, irq_external, mstatus, mie, mtvec,
               ex_valid, ex_stall, ex_pc, interrupt_taken, ecall_exception,
               ebreak_exception, mret_instruction,
        input  interrupt_pending, interrupt_cause, trap_vector, trap_csr_we,
               trap_csr_addr, trap_csr_wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/trap_controller.sv
`default_nettype none
// ============================================================================
// trap_controller : machine-mode trap entry/exit sequencer (mepc/mcause/mstatus)
// Optional feature macro: TRAP_VECTORED_EN (vectored interrupt handler address)
// Rev 1.0 : initial release
// ============================================================================
module trap_controller #(
    parameter logic [31:0] MEPC_ALIGN_MASK = 32'hFFFFFFFC
) (
    input  logic              clk,
    input  logic              rst,
    trap_controller_if.master bus
);
    localparam logic [11:0] c_CSR_MEPC    = 12'h341;
    localparam logic [11:0] c_CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] c_CSR_MSTATUS = 12'h300;
    localparam logic [31:0] c_CAUSE_MEI   = 32'h8000000B;
    localparam logic [31:0] c_CAUSE_MSI   = 32'h80000003;
    localparam logic [31:0] c_CAUSE_MTI   = 32'h80000007;
    localparam logic [31:0] c_CAUSE_ECALL = 32'h0000000B;
    localparam logic [31:0] c_CAUSE_EBRK  = 32'h00000003;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_W_MEPC    = 3'd2,
        S_W_MCAUSE  = 3'd3,
        S_W_MSTATUS = 3'd4,
        S_W_MRET    = 3'd5
    } state_t;

    state_t      state_q;
    logic        pending_q;
    logic [31:0] cause_q;
    logic        we_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;
    logic        busy_q;

    logic [31:0] w_irq_cause;
    logic        w_irq_req;
    logic [31:0] w_pc_masked;
    logic [31:0] w_trap_status;
    logic [31:0] w_mret_status;
    logic [31:0] w_vec_base;

    always_comb begin
        w_irq_cause = '0;
        if (bus.irq_external && bus.mie[11]) begin
            w_irq_cause = c_CAUSE_MEI;
        end else if (bus.irq_software && bus.mie[3]) begin
            w_irq_cause = c_CAUSE_MSI;
        end else if (bus.irq_timer && bus.mie[7]) begin
            w_irq_cause = c_CAUSE_MTI;
        end
    end

    assign w_irq_req     = bus.mstatus[3] && (w_irq_cause != '0);
    assign w_pc_masked   = bus.ex_pc & MEPC_ALIGN_MASK;
    // Entry: MPIE <- MIE, MIE <- 0, MPP <- M.  Exit: MIE <- MPIE, MPIE <- 1, MPP <- U.
    assign w_trap_status = {bus.mstatus[31:13], 2'b11, bus.mstatus[10:8],
                            bus.mstatus[3], bus.mstatus[6:4], 1'b0, bus.mstatus[2:0]};
    assign w_mret_status = {bus.mstatus[31:13], 2'b00, bus.mstatus[10:8],
                            1'b1, bus.mstatus[6:4], bus.mstatus[7], bus.mstatus[2:0]};
    assign w_vec_base    = {bus.mtvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    logic       w_cur_is_irq;
    logic [4:0] w_cur_code;

    // In IDLE the trap about to be requested decides; an mret never vectors.
    always_comb begin
        w_cur_is_irq = 1'b0;
        w_cur_code   = '0;
        if (state_q == S_IDLE) begin
            w_cur_is_irq = w_irq_req;
            w_cur_code   = w_irq_cause[4:0];
        end else if (state_q != S_W_MRET) begin
            w_cur_is_irq = cause_q[31];
            w_cur_code   = cause_q[4:0];
        end
    end

    assign bus.trap_vector = (bus.mtvec[1:0] == 2'b01 && w_cur_is_irq)
                           ? w_vec_base + {25'd0, w_cur_code, 2'b00}
                           : w_vec_base;
`else
    logic w_unused_mode;
    assign w_unused_mode   = ^bus.mtvec[1:0];
    assign bus.trap_vector = w_vec_base;
`endif

    logic w_unused_mie;
    assign w_unused_mie = ^{bus.mie[31:12], bus.mie[10:8], bus.mie[6:4], bus.mie[2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            cause_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_irq_req && bus.ex_valid && !bus.ex_stall) begin
                        state_q   <= S_REQ;
                        cause_q   <= w_irq_cause;
                        pending_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else if (bus.ecall_exception || bus.ebreak_exception) begin
                        state_q <= S_W_MEPC;
                        cause_q <= bus.ecall_exception ? c_CAUSE_ECALL : c_CAUSE_EBRK;
                        busy_q  <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= c_CSR_MEPC;
                        wdata_q <= w_pc_masked;
                    end else if (bus.mret_instruction) begin
                        state_q <= S_W_MRET;
                        busy_q  <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= c_CSR_MSTATUS;
                        wdata_q <= w_mret_status;
                    end
                end
                S_REQ: begin
                    if (bus.interrupt_taken) begin
                        state_q   <= S_W_MEPC;
                        pending_q <= 1'b0;
                        we_q      <= 1'b1;
                        addr_q    <= c_CSR_MEPC;
                        wdata_q   <= w_pc_masked;
                    end else if (!w_irq_req || !bus.ex_valid) begin
                        state_q   <= S_IDLE;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                S_W_MEPC: begin
                    state_q <= S_W_MCAUSE;
                    we_q    <= 1'b1;
                    addr_q  <= c_CSR_MCAUSE;
                    wdata_q <= cause_q;
                end
                S_W_MCAUSE: begin
                    state_q <= S_W_MSTATUS;
                    we_q    <= 1'b1;
                    addr_q  <= c_CSR_MSTATUS;
                    wdata_q <= w_trap_status;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.interrupt_pending = pending_q;
    assign bus.interrupt_cause   = cause_q;
    assign bus.trap_csr_we       = we_q;
    assign bus.trap_csr_addr     = addr_q;
    assign bus.trap_csr_wdata    = wdata_q;
    assign bus.busy              = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_trap_controller.sv
`default_nettype none
// ============================================================================
// tb_trap_controller : directed stimulus with a transaction-level trap model
// Rev 1.0 : initial release
// ============================================================================
module tb_trap_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    trap_controller_if bus();

    trap_controller #(.MEPC_ALIGN_MASK(32'hFFFFFFFC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          busy;
        bit          pend;
        bit          we;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] tcause;
    } frame_t;

    frame_t        sched[$];
    bit            m_req   = 1'b0;
    logic [31:0]   m_cause = '0;
    logic [43:0]   wr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] irq_cause_now();
        if (!bus.mstatus[3])                       return 32'h0;
        if (bus.irq_external && bus.mie[11])       return 32'h8000000B;
        if (bus.irq_software && bus.mie[3])        return 32'h80000003;
        if (bus.irq_timer && bus.mie[7])           return 32'h80000007;
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_vector(input logic [31:0] tc);
        logic [31:0] base;
        base = bus.mtvec & 32'hFFFFFFFC;
`ifdef TRAP_VECTORED_EN
        if (bus.mtvec[1:0] == 2'b01 && tc[31]) return base + 32'(tc[4:0]) * 4;
`endif
        return base;
    endfunction

    function automatic frame_t mk(input logic [11:0] a, input logic [31:0] d, input logic [31:0] tc);
        frame_t f;
        f.busy = 1'b1; f.pend = 1'b0; f.we = 1'b1; f.addr = a; f.data = d; f.tcause = tc;
        return f;
    endfunction

    task automatic push_trap(input logic [31:0] pc, input logic [31:0] cause);
        logic [31:0] ms;
        ms = bus.mstatus;
        ms = (ms & ~32'h0000_1888) | 32'h0000_1800 | (bus.mstatus[3] ? 32'h80 : 32'h0);
        sched.push_back(mk(12'h341, pc & 32'hFFFFFFFC, cause));
        sched.push_back(mk(12'h342, cause, cause));
        sched.push_back(mk(12'h300, ms, cause));
    endtask

    // Compare the current cycle against the model, then advance the model on current inputs.
    always @(negedge clk) begin
        frame_t      e;
        logic [31:0] c;
        bit          was_idle;
        c = irq_cause_now();
        e = '{busy: 1'b0, pend: 1'b0, we: 1'b0, addr: '0, data: '0, tcause: '0};
        if (!rst) begin
            if (m_req) begin
                e.busy = 1'b1; e.pend = 1'b1; e.tcause = m_cause;
            end else if (sched.size() != 0) begin
                e = sched[0];
            end else begin
                e.tcause = c;
            end
        end
        chk("busy", 32'(bus.busy), 32'(e.busy));
        chk("pending", 32'(bus.interrupt_pending), 32'(e.pend));
        chk("csr_we", 32'(bus.trap_csr_we), 32'(e.we));
        chk("trap_vector", bus.trap_vector, exp_vector(e.tcause));
        if (e.we || rst) begin
            chk("csr_addr", 32'(bus.trap_csr_addr), 32'(e.addr));
            chk("csr_wdata", bus.trap_csr_wdata, e.data);
        end
        if (rst)         chk("cause_rst", bus.interrupt_cause, 32'h0);
        else if (e.pend) chk("cause", bus.interrupt_cause, m_cause);
        if (!rst && bus.trap_csr_we) wr_log.push_back({bus.trap_csr_addr, bus.trap_csr_wdata});

        if (rst) begin
            sched.delete();
            m_req = 1'b0;
        end else begin
            was_idle = !m_req && sched.size() == 0;
            if (sched.size() != 0) void'(sched.pop_front());
            if (m_req) begin
                if (bus.interrupt_taken) begin
                    m_req = 1'b0;
                    push_trap(bus.ex_pc, m_cause);
                end else if (c == 0 || !bus.ex_valid) begin
                    m_req = 1'b0;
                end
            end else if (was_idle) begin
                if (c != 0 && bus.ex_valid && !bus.ex_stall) begin
                    m_req = 1'b1; m_cause = c;
                end else if (bus.ecall_exception) begin
                    push_trap(bus.ex_pc, 32'h0000000B);
                end else if (bus.ebreak_exception) begin
                    push_trap(bus.ex_pc, 32'h00000003);
                end else if (bus.mret_instruction) begin
                    sched.push_back(mk(12'h300, (bus.mstatus & ~32'h0000_1888) | 32'h80
                                                | (bus.mstatus[7] ? 32'h8 : 32'h0), 32'h0));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_log(input int idx, input logic [11:0] a, input logic [31:0] d);
        logic [43:0] ent;
        ent = (wr_log.size() > idx) ? wr_log[idx] : 44'hFFF_FFFFFFFF;
        chk($sformatf("log%0d_addr", idx), 32'(ent[43:32]), 32'(a));
        chk($sformatf("log%0d_data", idx), ent[31:0], d);
    endtask

    initial begin
        bus.irq_software = 0; bus.irq_timer = 0; bus.irq_external = 0;
        bus.mstatus = 32'h0; bus.mie = 32'h0; bus.mtvec = 32'h0000_1001;
        bus.ex_valid = 0; bus.ex_stall = 0; bus.ex_pc = 32'h0;
        bus.interrupt_taken = 0; bus.ecall_exception = 0;
        bus.ebreak_exception = 0; bus.mret_instruction = 0;
        step(3);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_cause", bus.interrupt_cause, 32'h0);
        rst = 1'b0;
        step(2);

        // Timer interrupt entry
        wr_log.delete();
        bus.mstatus = 32'h8; bus.mie = 32'h80; bus.irq_timer = 1; bus.ex_valid = 1; bus.ex_pc = 32'h100;
        step(1);
        chk("t1_pending", 32'(bus.interrupt_pending), 32'h1);
        chk("t1_cause", bus.interrupt_cause, 32'h80000007);
        bus.interrupt_taken = 1;
        step(1);
        bus.interrupt_taken = 0; bus.irq_timer = 0; bus.ex_valid = 0;
        step(5);
        chk("t1_nwr", wr_log.size(), 32'd3);
        chk_log(0, 12'h341, 32'h100);
        chk_log(1, 12'h342, 32'h80000007);
        chk_log(2, 12'h300, 32'h1880);

        // External beats timer; simultaneous ecall is dropped
        wr_log.delete();
        bus.mie = 32'h880; bus.irq_external = 1; bus.irq_timer = 1; bus.ex_valid = 1;
        bus.ex_pc = 32'h240; bus.ecall_exception = 1;
        step(1);
        bus.ecall_exception = 0;
        chk("t2_cause", bus.interrupt_cause, 32'h8000000B);
`ifdef TRAP_VECTORED_EN
        chk("t2_vector", bus.trap_vector, 32'h102C);
`else
        chk("t2_vector", bus.trap_vector, 32'h1000);
`endif
        bus.interrupt_taken = 1;
        step(1);
        bus.interrupt_taken = 0;
        step(4);
        chk_log(1, 12'h342, 32'h8000000B);
        // Updated mstatus has MIE=0: lines still high must not re-request
        bus.mstatus = 32'h1880;
        step(3);
        chk("t2_blocked", 32'(bus.interrupt_pending), 32'h0);
        bus.irq_external = 0; bus.irq_timer = 0; bus.ex_valid = 0;
        step(1);

        // ecall with misaligned PC, ebreak during busy ignored, then mret
        wr_log.delete();
        bus.mstatus = 32'h8; bus.mie = 32'h0; bus.ex_pc = 32'h206; bus.ecall_exception = 1;
        step(1);
        bus.ecall_exception = 0; bus.ebreak_exception = 1;
        chk("t3_vector", bus.trap_vector, 32'h1000);
        step(1);
        bus.ebreak_exception = 0;
        step(4);
        chk("t3_nwr", wr_log.size(), 32'd3);
        chk_log(0, 12'h341, 32'h204);
        chk_log(1, 12'h342, 32'h0000000B);
        chk_log(2, 12'h300, 32'h1880);
        wr_log.delete();
        bus.mstatus = 32'h1880; bus.mret_instruction = 1;
        step(1);
        bus.mret_instruction = 0;
        step(3);
        chk("t3_mret_nwr", wr_log.size(), 32'd1);
        chk_log(0, 12'h300, 32'h88);
        bus.mstatus = 32'h0; bus.ex_pc = 32'h300; bus.ebreak_exception = 1;
        step(1);
        bus.ebreak_exception = 0;
        step(4);

        // Stall delays request; withdrawal by source drop and by ex_valid fall
        wr_log.delete();
        bus.mstatus = 32'h8; bus.mie = 32'h8; bus.irq_software = 1; bus.ex_valid = 1; bus.ex_stall = 1;
        step(2);
        chk("t4_stalled", 32'(bus.interrupt_pending), 32'h0);
        bus.ex_stall = 0;
        step(1);
        chk("t4_pending", 32'(bus.interrupt_pending), 32'h1);
        bus.irq_software = 0;
        step(1);
        chk("t4_withdrawn", 32'(bus.busy), 32'h0);
        bus.irq_software = 1;
        step(2);
        bus.ex_valid = 0;
        step(3);
        bus.irq_software = 0;
        chk("t4_nwr", wr_log.size(), 32'd0);

        // Reset in W_MCAUSE aborts the sequence
        wr_log.delete();
        bus.ex_pc = 32'h400; bus.ecall_exception = 1;
        step(1);
        bus.ecall_exception = 0;
        step(1);
        rst = 1'b1;
        #1;
        chk("t5_busy", 32'(bus.busy), 32'h0);
        chk("t5_we", 32'(bus.trap_csr_we), 32'h0);
        chk("t5_addr", 32'(bus.trap_csr_addr), 32'h0);
        chk("t5_wdata", bus.trap_csr_wdata, 32'h0);
        chk("t5_cause", bus.interrupt_cause, 32'h0);
        step(2);
        rst = 1'b0;
        step(5);
        chk("t5_nwr", wr_log.size(), 32'd1);
        chk_log(0, 12'h341, 32'h400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
